// File: rtl/mbgd_pkg.sv
// Shared parameters and state encoding for the mini-batch gradient accumulator.
package mbgd_pkg;

  localparam int unsigned N         = 8;
  localparam int unsigned DW        = 8;
  localparam int unsigned BATCH     = 4;
  localparam int unsigned BATCH_BIT = 2;
  localparam int unsigned ACC_W     = 2 * DW + BATCH_BIT;

  // Lane-slice helpers: packed vector widths and counter width.
  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned VEC_W  = DW * N;
  localparam int unsigned GRAD_W = ACC_W * N;
  localparam int unsigned CNT_W  = BATCH_BIT + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/mbgd_mac_lane.sv
// One gradient lane: registered signed multiply (S1) feeding a sign-extended accumulator (S2).
module mbgd_mac_lane
  import mbgd_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic [DW-1:0]           err,
  input  logic [DW-1:0]           feat,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      prod       <= PROD_W'($signed(err)) * PROD_W'($signed(feat));
      prod_valid <= en;
      if (prod_valid) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

endmodule

// File: rtl/mbgd_grad_accum.sv
// Mini-batch gradient accumulator: sums err*feat per lane over BATCH samples, holds result under valid/ready.
// Define MBGD_GRAD_MEAN_EN to present the rounded mean instead of the raw batch sum.
module mbgd_grad_accum
  import mbgd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  err,
  input  logic [VEC_W-1:0]  feat,
  output logic [GRAD_W-1:0] grad,
  output logic              grad_valid,
  input  logic              grad_ready,
  output logic [CNT_W-1:0]  sample_cnt
);

  state_t                   state;
  logic                     accept_c;
  logic                     clear_c;
  logic                     last_s1;
  logic                     last_s2;
  logic signed [ACC_W-1:0]  acc [N];
  logic [GRAD_W-1:0]        grad_next;

  assign accept_c = in_valid && in_ready;
  assign clear_c  = grad_valid && grad_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mbgd_mac_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .clear (clear_c),
      .en    (accept_c),
      .err   (err[DW*i +: DW]),
      .feat  (feat[DW*i +: DW]),
      .acc   (acc[i])
    );
  end

`ifdef MBGD_GRAD_MEAN_EN
  localparam logic signed [ACC_W-1:0] MEAN_RND = ACC_W'(1 << (BATCH_BIT - 1));
  logic signed [ACC_W-1:0] rounded [N];

  // Round-half-up mean; the arithmetic shift keeps the sign in the upper bits.
  always_comb begin
    grad_next = '0;
    for (int i = 0; i < N; i++) begin
      rounded[i]                    = acc[i] + MEAN_RND;
      grad_next[ACC_W*i +: ACC_W]   = rounded[i] >>> BATCH_BIT;
    end
  end
`else
  always_comb begin
    grad_next = '0;
    for (int i = 0; i < N; i++) begin
      grad_next[ACC_W*i +: ACC_W] = acc[i];
    end
  end
`endif

  // last_s1/last_s2 track the final sample of a batch through the two-stage lane pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      grad       <= '0;
      grad_valid <= 1'b0;
      sample_cnt <= '0;
      last_s1    <= 1'b0;
      last_s2    <= 1'b0;
    end else begin
      last_s1 <= accept_c && (sample_cnt == CNT_W'(BATCH - 1));
      last_s2 <= last_s1;
      if (accept_c) begin
        sample_cnt <= CNT_W'(sample_cnt + 1'b1);
        if (sample_cnt == CNT_W'(BATCH - 1)) begin
          in_ready <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (last_s2) begin
            state      <= HOLD;
            grad       <= grad_next;
            grad_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (grad_ready) begin
            state      <= IDLE;
            grad_valid <= 1'b0;
            sample_cnt <= '0;
            in_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbgd_grad_accum.sv
// Directed table-driven bench for mbgd_grad_accum (raw sum or MBGD_GRAD_MEAN_EN mean build).
module tb_mbgd_grad_accum;
  import mbgd_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  err;
  logic [VEC_W-1:0]  feat;
  logic [GRAD_W-1:0] grad;
  logic              grad_valid;
  logic              grad_ready;
  logic [CNT_W-1:0]  sample_cnt;

  int checks = 0;
  int errors = 0;

  mbgd_grad_accum dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .err        (err),
    .feat       (feat),
    .grad       (grad),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                 name;
    logic signed [DW-1:0]  e0  [N];
    logic signed [DW-1:0]  e   [N];
    logic signed [DW-1:0]  f   [N];
    longint                sum [N];
    longint                mean[N];
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] pack(input logic signed [DW-1:0] v[N]);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = v[i];
    return r;
  endfunction

  function automatic longint lane(input int i);
    logic signed [ACC_W-1:0] l;
    l = grad[ACC_W*i +: ACC_W];
    return longint'(l);
  endfunction

  task automatic send(input logic [VEC_W-1:0] ev, input logic [VEC_W-1:0] fv);
    in_valid = 1'b1;
    err      = ev;
    feat     = fv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_grad(input string nm, input longint s[N], input longint m[N]);
    for (int i = 0; i < N; i++) begin
`ifdef MBGD_GRAD_MEAN_EN
      chk($sformatf("%s_lane%0d", nm, i), lane(i), m[i]);
`else
      chk($sformatf("%s_lane%0d", nm, i), lane(i), s[i]);
`endif
    end
  endtask

  task automatic release_grad(input string nm);
    grad_ready = 1'b1;
    tick();
    grad_ready = 1'b0;
    chk({nm, "_rel_valid"}, grad_valid, 0);
    chk({nm, "_rel_ready"}, in_ready, 1);
    chk({nm, "_rel_cnt"}, sample_cnt, 0);
  endtask

  // Four back-to-back samples, then latency, result and release checks.
  task automatic run_entry(input int k, input bit do_release);
    chk({tbl[k].name, "_pre_ready"}, in_ready, 1);
    send(pack(tbl[k].e0), pack(tbl[k].f));
    for (int s = 1; s < BATCH; s++) send(pack(tbl[k].e), pack(tbl[k].f));
    chk({tbl[k].name, "_t0_valid"}, grad_valid, 0);
    chk({tbl[k].name, "_t0_ready"}, in_ready, 0);
    chk({tbl[k].name, "_t0_cnt"}, sample_cnt, BATCH);
    tick();
    chk({tbl[k].name, "_t1_valid"}, grad_valid, 0);
    tick();
    chk({tbl[k].name, "_t2_valid"}, grad_valid, 1);
    check_grad(tbl[k].name, tbl[k].sum, tbl[k].mean);
    if (do_release) release_grad(tbl[k].name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GRAD_W-1:0] held;
    longint s24[N];
    longint m6[N];
    logic signed [DW-1:0] v1[N];
    logic signed [DW-1:0] v2[N];
    logic signed [DW-1:0] v3[N];

    for (int i = 0; i < N; i++) begin
      tbl[0].name = "uniform";  tbl[0].e0[i] = 3;    tbl[0].e[i] = 3;    tbl[0].f[i] = 5;
      tbl[0].sum[i] = 60;      tbl[0].mean[i] = 15;
      tbl[1].name = "signed";   tbl[1].e0[i] = DW'(i - 4); tbl[1].e[i] = DW'(i - 4); tbl[1].f[i] = 2;
      tbl[1].sum[i] = 8 * (i - 4); tbl[1].mean[i] = 2 * (i - 4);
      tbl[2].name = "ext_pos";  tbl[2].e0[i] = -128; tbl[2].e[i] = -128; tbl[2].f[i] = -128;
      tbl[2].sum[i] = 65536;   tbl[2].mean[i] = 16384;
      tbl[3].name = "ext_neg";  tbl[3].e0[i] = -128; tbl[3].e[i] = -128; tbl[3].f[i] = 127;
      tbl[3].sum[i] = -65024;  tbl[3].mean[i] = -16256;
      tbl[4].name = "rounding"; tbl[4].e0[i] = 1;    tbl[4].e[i] = 0;    tbl[4].f[i] = DW'(i - 4);
      tbl[4].sum[i] = i - 4;
    end
    tbl[4].mean = '{-1, -1, 0, 0, 0, 0, 1, 1};

    // Reset with in_valid asserted must not accept anything.
    reset = 1'b1; in_valid = 1'b1; grad_ready = 1'b0; err = '1; feat = '1;
    tick();
    tick();
    chk("rst_grad", (grad == '0) ? 1 : 0, 1);
    chk("rst_valid", grad_valid, 0);
    chk("rst_cnt", sample_cnt, 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt_after", sample_cnt, 0);

    for (int k = 0; k < 5; k++) run_entry(k, 1'b1);

    // Backpressure: HOLD keeps grad stable and ignores new input.
    run_entry(0, 1'b0);
    held = grad;
    grad_ready = 1'b0;
    for (int i = 0; i < N; i++) v1[i] = 7;
    in_valid = 1'b1; err = pack(v1); feat = pack(v1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_stable%0d", c), (grad == held) ? 1 : 0, 1);
      chk($sformatf("bp_valid%0d", c), grad_valid, 1);
      chk($sformatf("bp_ready%0d", c), in_ready, 0);
      chk($sformatf("bp_cnt%0d", c), sample_cnt, BATCH);
    end
    in_valid = 1'b0;
    release_grad("bp");
    run_entry(1, 1'b1);

    // Partial batch, reset, then a bubbled batch: only the post-reset samples count.
    for (int i = 0; i < N; i++) begin
      v1[i] = 1; v2[i] = 2; v3[i] = 3; s24[i] = 24; m6[i] = 6;
    end
    send(pack(v1), pack(v1));
    send(pack(v1), pack(v1));
    chk("mid_cnt", sample_cnt, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_cnt", sample_cnt, 0);
    tick();
    for (int s = 0; s < BATCH; s++) begin
      send(pack(v2), pack(v3));
      tick();
      tick();
    end
    for (int c = 0; c < 12 && !grad_valid; c++) tick();
    chk("bubble_valid", grad_valid, 1);
    check_grad("bubble", s24, m6);
    release_grad("bubble");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
